// File: rtl/uw_payload_derotator.sv
// Circular symbol buffer that replays the post-UW payload, phase-corrected, on each resolver lock.
// Latency: first symbol 3 cycles after the lock edge; 1 symbol per 3 cycles max; HOLD stalls on out_ready.
module uw_payload_derotator #(
  parameter int ADDR_W      = 14,
  parameter int UW_SYMS     = 16,
  parameter int PAYLOAD_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        sym_in,
  input  logic              sym_in_valid,
  input  logic [1:0]        best_rot,
  input  logic [ADDR_W-1:0] match_index,
  input  logic              lock_valid,
  output logic [1:0]        out_sym,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] UW_OFF      = ADDR_W'(UW_SYMS);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0]  PAYLOAD_CNT = CNT_W'(PAYLOAD_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rot_q, rot_d;
  logic              lock_q, lock_d;
  logic [1:0]        out_sym_q, out_sym_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;

  logic [1:0]        mem [DEPTH];
  logic [1:0]        ram_dat_q;
  logic              rd_en;
  logic              lock_edge;
  logic              lap;
  logic [1:0]        derot_sym;

  // Undo k*90 deg CCW: multiply the constellation point by (-j)^k.
  function automatic logic [1:0] derotate(input logic [1:0] s, input logic [1:0] k);
    logic [1:0] r;
    case (k)
      2'd0:    r = s;
      2'd1:    r = {~s[0], s[1]};
      2'd2:    r = {~s[1], ~s[0]};
      default: r = {s[0], ~s[1]};
    endcase
    return r;
  endfunction

  always_comb begin
    lock_d      = lock_valid;
    lock_edge   = lock_valid & ~lock_q;
    wr_ptr_d    = sym_in_valid ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    lap         = sym_in_valid && (state_q != S_IDLE) && ((wr_ptr_q + PTR_ONE) == rd_ptr_q);
    derot_sym   = derotate(ram_dat_q, rot_q);

    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rot_d       = rot_q;
    out_sym_d   = out_sym_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    overrun_d   = overrun_q;
    rd_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lock_edge) begin
          rot_d    = best_rot;
          rd_ptr_d = match_index + UW_OFF;
          cnt_d    = PAYLOAD_CNT;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // rd_ptr == wr_ptr means the slot is unwritten (or being written this cycle).
        if (rd_ptr_q != wr_ptr_q) begin
          rd_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        out_sym_d   = derot_sym;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == CNT_ONE);
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        cnt_d       = cnt_q - CNT_ONE;
        state_d     = S_HOLD;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = (cnt_q == CNT_ZERO) ? S_IDLE : S_WAIT;
        end
      end
    endcase

    // Writer lapping the reader corrupts unread payload: abandon the frame.
    if (lap) begin
      overrun_d   = 1'b1;
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      rd_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sym_in_valid) begin
      mem[wr_ptr_q] <= sym_in;
    end
    if (rd_en) begin
      ram_dat_q <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rot_q       <= '0;
      lock_q      <= 1'b0;
      out_sym_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rot_q       <= rot_d;
      lock_q      <= lock_d;
      out_sym_q   <= out_sym_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_sym   = out_sym_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uw_payload_derotator.sv
// Bench for uw_payload_derotator: randomized data against a complex-arithmetic reference of the payload.
module tb_uw_payload_derotator;

  localparam int ADDR_W = 6;
  localparam int UW     = 4;
  localparam int PL     = 8;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        sym_in = '0;
  logic              sym_in_valid = 1'b0;
  logic [1:0]        best_rot = '0;
  logic [ADDR_W-1:0] match_index = '0;
  logic              lock_valid = 1'b0;
  logic [1:0]        out_sym;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  logic [1:0] mm [DEPTH];
  int mwr = 0;

  uw_payload_derotator #(.ADDR_W(ADDR_W), .UW_SYMS(UW), .PAYLOAD_LEN(PL)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_in_valid(sym_in_valid),
    .best_rot(best_rot), .match_index(match_index), .lock_valid(lock_valid),
    .out_sym(out_sym), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference: map bits to +/-1, multiply I+jQ by (-j) once per quarter turn, map back.
  function automatic logic [1:0] model_derot(input logic [1:0] s, input int rot);
    int ii, qq, t;
    ii = s[0] ? -1 : 1;
    qq = s[1] ? -1 : 1;
    for (int r = 0; r < rot; r++) begin
      t  = ii;
      ii = qq;
      qq = -t;
    end
    return {qq < 0, ii < 0};
  endfunction

  function automatic logic [1:0] exp_sym(input int idx, input int k, input int rot);
    return model_derot(mm[(idx + UW + k) % DEPTH], rot);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    sym_in_valid = 1'b0;
    lock_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mwr = 0;
  endtask

  // mode 0: symbol value = buffer address[1:0]; mode 1: random
  task automatic write_syms(input int n, input int mode);
    logic [1:0] sv;
    for (int i = 0; i < n; i++) begin
      sv = (mode == 0) ? 2'(mwr % DEPTH) : 2'($urandom_range(0, 3));
      sym_in = sv;
      sym_in_valid = 1'b1;
      mm[mwr % DEPTH] = sv;
      mwr++;
      @(posedge clk);
      #1;
    end
    sym_in_valid = 1'b0;
  endtask

  task automatic pulse_lock(input int rot, input int idx);
    best_rot = 2'(rot);
    match_index = ADDR_W'(idx);
    lock_valid = 1'b1;
    @(posedge clk);
    #1;
    lock_valid = 1'b0;
  endtask

  task automatic get_sym(output logic [1:0] s, output logic l, output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    s = '0;
    l = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) begin
        s = out_sym;
        l = out_last;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_sym, out_valid, out_last, busy, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000", {out_sym, out_valid, out_last, busy, overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    write_syms(20, 0);
    pulse_lock(0, 2);
    for (int k = 0; k < PL; k++) begin
      get_sym(s, l, cyc, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout[%0d] got no out_valid exp out_valid", k); end
      if (k == 0) begin
        checks++;
        if (cyc + 1 != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", cyc + 1); end
      end
      checks++;
      if (s !== exp_sym(2, k, 0) || l !== (k == PL - 1)) begin
        errors++;
        $display("FAIL basic_sym[%0d] got %b/%b exp %b/%b", k, s, l, exp_sym(2, k, 0), k == PL - 1);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
  endtask

  task automatic test_rotations();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    do_reset();
    out_ready = 1'b1;
    write_syms(20, 0);
    for (int rot = 0; rot < 4; rot++) begin
      pulse_lock(rot, 2);
      for (int k = 0; k < PL; k++) begin
        get_sym(s, l, cyc, ok);
        checks++;
        if (!ok || s !== exp_sym(2, k, rot)) begin
          errors++;
          $display("FAIL rot%0d_sym[%0d] got %b ok=%0d exp %b", rot, k, s, ok, exp_sym(2, k, rot));
        end
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    int rot;
    do_reset();
    out_ready = 1'b1;
    write_syms(DEPTH + PL, 1);
    rot = $urandom_range(0, 3);
    pulse_lock(rot, 60);
    for (int k = 0; k < PL; k++) begin
      get_sym(s, l, cyc, ok);
      checks++;
      if (!ok || s !== exp_sym(60, k, rot) || l !== (k == PL - 1)) begin
        errors++;
        $display("FAIL wrap_sym[%0d] got %b/%b ok=%0d exp %b/%b", k, s, l, ok, exp_sym(60, k, rot), k == PL - 1);
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    bit seen;
    do_reset();
    out_ready = 1'b1;
    write_syms(2 + UW + PL - 1, 1);
    pulse_lock(1, 2);
    for (int k = 0; k < PL - 1; k++) begin
      get_sym(s, l, cyc, ok);
      checks++;
      if (!ok || s !== exp_sym(2, k, 1) || l !== 1'b0) begin
        errors++;
        $display("FAIL stall_sym[%0d] got %b/%b ok=%0d exp %b/0", k, s, l, ok, exp_sym(2, k, 1));
      end
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL stall_wait got valid/idle=1 exp busy-wait"); end
    write_syms(1, 1);
    get_sym(s, l, cyc, ok);
    checks++;
    if (!ok || s !== exp_sym(2, PL - 1, 1) || l !== 1'b1) begin
      errors++;
      $display("FAIL stall_last got %b/%b ok=%0d exp %b/1", s, l, ok, exp_sym(2, PL - 1, 1));
    end
  endtask

  task automatic test_hold_and_ignore();
    logic [1:0] s, s0;
    logic l;
    int cyc;
    bit ok;
    bit moved;
    int count;
    do_reset();
    out_ready = 1'b0;
    write_syms(20, 1);
    pulse_lock(2, 2);
    get_sym(s0, l, cyc, ok);
    checks++;
    if (!ok || s0 !== exp_sym(2, 0, 2)) begin
      errors++;
      $display("FAIL hold_first got %b ok=%0d exp %b", s0, ok, exp_sym(2, 0, 2));
    end
    moved = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin best_rot = 2'd3; match_index = 6'd10; lock_valid = 1'b1; end
      if (i == 2) lock_valid = 1'b0;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_sym !== s0 || out_last !== 1'b0) moved = 1'b1;
    end
    lock_valid = 1'b0;
    checks++;
    if (moved) begin errors++; $display("FAIL hold_stable got change exp stable %b", s0); end
    out_ready = 1'b1;
    count = 1;
    for (int k = 1; k < PL + 2; k++) begin
      get_sym(s, l, cyc, ok);
      if (!ok) break;
      count++;
      checks++;
      if (s !== exp_sym(2, k, 2)) begin
        errors++;
        $display("FAIL hold_sym[%0d] got %b exp %b", k, s, exp_sym(2, k, 2));
      end
    end
    checks++;
    if (count != PL || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_count got %0d busy=%b exp %0d busy=0", count, busy, PL);
    end
  endtask

  task automatic test_overrun();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    bit early;
    int addr;
    do_reset();
    out_ready = 1'b0;
    write_syms(20, 1);
    pulse_lock(0, 2);
    get_sym(s, l, cyc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovr_first got no out_valid exp out_valid"); end
    early = 1'b0;
    addr = 0;
    for (int i = 0; i < 80; i++) begin
      addr = mwr % DEPTH;
      sym_in = 2'($urandom_range(0, 3));
      sym_in_valid = 1'b1;
      mm[addr] = sym_in;
      mwr++;
      @(posedge clk);
      #1;
      if (addr == 2 + UW) break;
      if (overrun || !busy) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL ovr_early got overrun/idle before lap exp none"); end
    checks++;
    if ({overrun, busy, out_valid, out_last} !== 4'b1000) begin
      errors++;
      $display("FAIL ovr_flag got %b exp 1000", {overrun, busy, out_valid, out_last});
    end
    sym_in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [1:0] s;
    logic l;
    int cyc;
    bit ok;
    out_ready = 1'b0;
    pulse_lock(0, 40);
    get_sym(s, l, cyc, ok);
    checks++;
    if (!ok || overrun !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got valid=%0d overrun=%b exp 1/1", ok, overrun);
    end
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_sym, out_valid, out_last, busy, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL arst_outputs got %b exp 000000", {out_sym, out_valid, out_last, busy, overrun});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mwr = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotations();
    test_wrap();
    test_stall();
    test_hold_and_ignore();
    test_overrun();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
